// File: rtl/serial_operand_shifter.sv
// Parallel-load, serial-out operand shifter with bit counter and Busy/Done handshake
// for the serial adder datapath. One instance per operand.
module serial_operand_shifter #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             L,
    input  logic [WIDTH-1:0] Load,
    input  logic             EN,
    input  logic             ROT,
    input  logic             Sin,
    output logic             Sout,
    output logic             Busy,
    output logic             Done,
    output logic [CW-1:0]    Cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;

    // Shift by one toward the output end and insert the new bit at the far end;
    // written with whole-vector shifts so WIDTH=1 collapses cleanly to sr <= in.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic in);
        logic [WIDTH-1:0] r;
        if (LSB_FIRST) begin
            r            = cur >> 1;
            r[WIDTH-1]   = in;
        end else begin
            r            = cur << 1;
            r[0]         = in;
        end
        return r;
    endfunction

    assign Sout = LSB_FIRST ? sr[0] : sr[WIDTH-1];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sr    <= '0;
            Cnt   <= '0;
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else if (L) begin
            // A load in any state restarts with the new operand and a full count.
            sr    <= Load;
            Cnt   <= CW'(WIDTH);
            state <= SHIFT;
            Busy  <= 1'b1;
            Done  <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (EN) begin
                        sr  <= shift_in(sr, ROT ? Sout : Sin);
                        Cnt <= Cnt - CW'(1);
                        if (Cnt == CW'(1)) begin
                            state <= DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Bench for serial_operand_shifter: an LSB-first and an MSB-first instance share stimulus
// and are compared every cycle against a queue-based model, plus directed sequences.
module tb_serial_operand_shifter;

    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       L = 1'b0;
    logic [7:0] Load = '0;
    logic       EN = 1'b0;
    logic       ROT = 1'b0;
    logic       Sin = 1'b0;
    logic       sout_a, busy_a, done_a;
    logic       sout_b, busy_b, done_b;
    logic [3:0] cnt_a, cnt_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    serial_operand_shifter #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .L(L), .Load(Load), .EN(EN), .ROT(ROT), .Sin(Sin),
        .Sout(sout_a), .Busy(busy_a), .Done(done_a), .Cnt(cnt_a)
    );

    serial_operand_shifter #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .L(L), .Load(Load), .EN(EN), .ROT(ROT), .Sin(Sin),
        .Sout(sout_b), .Busy(busy_b), .Done(done_b), .Cnt(cnt_b)
    );

    // Model: each register is a queue of bits in the order they leave; a shift pops the
    // front and appends the incoming bit. rem counts bits left, mdone flags the pulse.
    bit qa[$];
    bit qb[$];
    int rem = 0;
    bit mdone = 1'b0;

    typedef struct {
        logic       rst_n;
        logic       l;
        logic [7:0] load;
        logic       en;
        logic       rot;
        logic       sin;
        logic       sout;
        logic       busy;
        logic       done;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit b;
        if (!RST_N) begin
            qa.delete(); qb.delete();
            for (int i = 0; i < W; i++) begin qa.push_back(1'b0); qb.push_back(1'b0); end
            rem = 0;
            mdone = 1'b0;
        end else if (L) begin
            qa.delete(); qb.delete();
            for (int i = 0; i < W; i++) begin
                qa.push_back(Load[i]);
                qb.push_back(Load[W-1-i]);
            end
            rem = W;
            mdone = 1'b0;
        end else begin
            mdone = 1'b0;
            if (rem > 0 && EN) begin
                b = qa.pop_front(); qa.push_back(ROT ? b : Sin);
                b = qb.pop_front(); qb.push_back(ROT ? b : Sin);
                rem--;
                if (rem == 0) mdone = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        chk("model_sout_lsb", 32'(sout_a), 32'(qa[0]));
        chk("model_sout_msb", 32'(sout_b), 32'(qb[0]));
        chk("model_busy", {30'b0, busy_b, busy_a}, {30'b0, rem != 0, rem != 0});
        chk("model_done", {30'b0, done_b, done_a}, {30'b0, mdone, mdone});
        chk("model_cnt", {cnt_b, cnt_a}, {rem[3:0], rem[3:0]});
    endtask

    task automatic apply(input logic rst_n, input logic l, input logic [7:0] ld,
                         input logic en, input logic rot, input logic sin);
        @(negedge CLK);
        RST_N = rst_n; L = l; Load = ld; EN = en; ROT = rot; Sin = sin;
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
    endtask

    logic [7:0] pat;

    initial begin
        for (int i = 0; i < W; i++) begin qa.push_back(1'b0); qb.push_back(1'b0); end

        // Directed table: reset, load 8'hA4, eight shifts with Sin=0, then idle.
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8};
        tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7};
        tbl[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[8] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rst_n, tbl[i].l, tbl[i].load, tbl[i].en, tbl[i].rot, tbl[i].sin);
            chk($sformatf("tbl%0d_sout", i), 32'(sout_a), 32'(tbl[i].sout));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i), 32'(done_a), 32'(tbl[i].done));
            chk($sformatf("tbl%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].cnt));
        end
        chk("t1_sr_lsb", 32'(dut.sr), 32'h00);
        chk("t1_sr_msb", 32'(dut_b.sr), 32'h00);

        // Rotate: operand returns intact; MSB-first order is 1,0,1,0,0,1,0,0.
        pat = 8'hA4;
        apply(1'b1, 1'b1, 8'hA4, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("t3_sout_msb", 32'(sout_b), 32'(pat[7-k]));
            chk("t2_sout_lsb", 32'(sout_a), 32'(pat[k]));
            apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        end
        chk("t2_done", 32'(done_a), 32'd1);
        chk("t2_sr_lsb", 32'(dut.sr), 32'hA4);
        chk("t2_sr_msb", 32'(dut_b.sr), 32'hA4);
        apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // Stall after three bits: Cnt and Sout frozen, then resume.
        apply(1'b1, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            chk("t4_stall_cnt", 32'(cnt_a), 32'd5);
            chk("t4_stall_sout", 32'(sout_a), 32'(pat[3]));
        end
        for (int k = 0; k < 5; k++) begin
            chk("t4_resume_sout", 32'(sout_a), 32'(pat[3+k]));
            apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("t4_done", 32'(done_a), 32'd1);

        // Reload mid-shift with EN high: restart, no Done for the first operand.
        apply(1'b1, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 8'h6D, 1'b1, 1'b0, 1'b0);
        chk("t5_cnt", 32'(cnt_a), 32'd8);
        pat = 8'h6D;
        for (int k = 0; k < 8; k++) begin
            chk("t5_sout", 32'(sout_a), 32'(pat[k]));
            chk("t5_no_done", 32'(done_a), 32'd0);
            apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("t5_done", 32'(done_a), 32'd1);

        // Reset mid-shift with L asserted.
        apply(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        chk("t6_busy", 32'(busy_a), 32'd0);
        chk("t6_done", 32'(done_a), 32'd0);
        chk("t6_cnt", 32'(cnt_a), 32'd0);
        chk("t6_sout", {30'b0, sout_b, sout_a}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            chk("t6_no_done", 32'(done_a), 32'd0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            apply($urandom_range(0, 49) != 0, $urandom_range(0, 11) == 0, 8'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
